// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   F3_*        : RV32I load/store funct3 codes
//   lsu_state_t : access sequencer states
//   lsu_req_t   : captured CPU request payload
//   size_bytes  : access size in bytes for a funct3
//   f3_legal    : funct3 legality for loads/stores
package riscv_lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} lsu_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            write;
    logic [2:0]      funct3;
  } lsu_req_t;

  // Low two funct3 bits encode the access size for every legal code.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3, input logic write);
    if (write) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle for lsu_mem_ctrl: CPU request/response and RAM port.
//   master : CPU + RAM environment (drives req_*, mem_rdata)
//   slave  : the load/store unit (drives req_ready, rsp_*, mem_* controls)
interface lsu_mem_ctrl_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MEM_AW = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_write, req_funct3, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_re, mem_we, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, req_funct3, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_re, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   Store path: off/size/wdata -> 8-lane byte enables and 64-bit shifted data.
//   Load path : two RAM words (hi = latest beat, lo = first beat of a split)
//               -> lane-shifted, sign/zero-extended result per funct3.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]      off,
  input  logic [2:0]      size,
  input  logic [2:0]      funct3,
  input  logic            split,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_hi,
  input  logic [XLEN-1:0] rdata_lo,
  output logic [7:0]      be8_c,
  output logic [63:0]     wd64_c,
  output logic [XLEN-1:0] load_c
);
  logic [7:0]      mask;
  logic [5:0]      sh;
  logic [63:0]     r64;
  logic [XLEN-1:0] r;

  assign sh = {1'b0, off, 3'b000};

  // Store lanes: mask of 'size' bytes moved up to the start offset.
  always_comb begin
    mask = 8'h0F;
    case (size)
      3'd1:    mask = 8'h01;
      3'd2:    mask = 8'h03;
      default: mask = 8'h0F;
    endcase
    be8_c  = mask << off;
    wd64_c = {32'h0, wdata} << sh;
  end

  // Load lanes: realign to bit 0, then extend.
  always_comb begin
    r64    = split ? {rdata_hi, rdata_lo} : {32'h0, rdata_hi};
    r      = XLEN'(r64 >> sh);
    load_c = r;
    case (funct3)
      F3_B:    load_c = {{24{r[7]}}, r[7:0]};
      F3_H:    load_c = {{16{r[15]}}, r[15:0]};
      F3_BU:   load_c = {24'h0, r[7:0]};
      F3_HU:   load_c = {16'h0, r[15:0]};
      default: load_c = r;
    endcase
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the CPU data port and a synchronous word RAM.
// One request per handshake; misaligned accesses crossing a word boundary
// take two RAM beats. All bus outputs are registered.
//   clk, reset (async, active-low)
//   bus (slave): req_valid/ready/addr/wdata/write/funct3, rsp_valid/rdata/err,
//                mem_addr/re/we/be/wdata, mem_rdata
// Optional: define LSU_MISALIGN_TRAP_EN to reject any access whose offset is
// not a multiple of its size (rsp_err, no RAM beats).
module lsu_mem_ctrl
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MEM_AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  lsu_mem_ctrl_if.slave bus
);
  lsu_state_t        state_q, state_n;
  lsu_req_t          req_in, req_q, req_sel;
  logic              err_q, err_n;
  logic              rdy_q;
  logic [WIDTH-1:0]  lo_q;

  logic              rsp_valid_q, rsp_valid_n;
  logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_n;
  logic              rsp_err_q, rsp_err_n;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_n;
  logic              mem_re_q, mem_re_n;
  logic              mem_we_q, mem_we_n;
  logic [3:0]        mem_be_q, mem_be_n;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_n;

  logic [1:0]        off;
  logic [2:0]        size;
  logic              split;
  logic [MEM_AW-1:0] word;
  logic              misalign;
  logic              accept;
  logic              bad;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [XLEN-1:0]   load_data;
  logic              unused_addr_hi;

  assign req_in = '{addr: bus.req_addr, wdata: bus.req_wdata,
                    write: bus.req_write, funct3: bus.req_funct3};

  // In IDLE the live request feeds the decode so BEAT0 outputs can be
  // registered on the accept edge; afterwards the captured copy is used.
  assign req_sel = (state_q == IDLE) ? req_in : req_q;

  assign off            = req_sel.addr[1:0];
  assign size           = size_bytes(req_sel.funct3);
  assign split          = (4'(off) + 4'(size)) > 4'd4;
  assign word           = req_sel.addr[MEM_AW+1:2];
  assign unused_addr_hi = ^req_sel.addr[XLEN-1:MEM_AW+2];
  assign accept         = bus.req_valid && rdy_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad = !f3_legal(req_sel.funct3, req_sel.write) || misalign;

  lsu_align u_align (
    .off      (off),
    .size     (size),
    .funct3   (req_sel.funct3),
    .split    (split),
    .wdata    (req_sel.wdata),
    .rdata_hi (bus.mem_rdata),
    .rdata_lo (lo_q),
    .be8_c    (be8),
    .wd64_c   (wd64),
    .load_c   (load_data)
  );

  // Next state, response, and the RAM controls for the state being entered.
  always_comb begin
    state_n     = state_q;
    err_n       = err_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = '0;
    rsp_err_n   = 1'b0;
    mem_addr_n  = '0;
    mem_re_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_be_n    = '0;
    mem_wdata_n = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_n   = bad;
          state_n = bad ? DONE : BEAT0;
        end
      end
      BEAT0:   state_n = split ? BEAT1 : DONE;
      BEAT1:   state_n = DONE;
      DONE: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b1;
        rsp_err_n   = err_q;
        rsp_rdata_n = (err_q || req_q.write) ? '0 : WIDTH'(load_data);
      end
    endcase

    case (state_n)
      BEAT0: begin
        mem_addr_n  = word;
        mem_be_n    = be8[3:0];
        mem_wdata_n = WIDTH'(wd64[31:0]);
        mem_we_n    = req_sel.write;
        mem_re_n    = !req_sel.write;
      end
      BEAT1: begin
        mem_addr_n  = word + MEM_AW'(1);
        mem_be_n    = be8[7:4];
        mem_wdata_n = WIDTH'(wd64[63:32]);
        mem_we_n    = req_sel.write;
        mem_re_n    = !req_sel.write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_n;
      err_q       <= err_n;
      rdy_q       <= (state_n == IDLE);
      if ((state_q == IDLE) && accept) req_q <= req_in;
      // First beat's read data is on mem_rdata during BEAT1.
      if (state_q == BEAT1) lo_q <= bus.mem_rdata;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_err_q   <= rsp_err_n;
      mem_addr_q  <= mem_addr_n;
      mem_re_q    <= mem_re_n;
      mem_we_q    <= mem_we_n;
      mem_be_q    <= mem_be_n;
      mem_wdata_q <= mem_wdata_n;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, hand-written
// split/wrap/reset sequences, and random traffic against a byte-array model.
module tb_lsu_mem_ctrl;
  import riscv_lsu_pkg::*;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned NWORDS = 1 << MEM_AW;
  localparam int unsigned NBYTES = NWORDS * 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic clr   = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.WIDTH(32), .MEM_AW(MEM_AW)) bus ();
  lsu_mem_ctrl #(.WIDTH(32), .MEM_AW(MEM_AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Synchronous RAM: read data appears the cycle after mem_re.
  logic [31:0] ram [NWORDS];
  logic [31:0] ram_q;
  assign bus.mem_rdata = ram_q;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(NWORDS); i++) ram[i] <= '0;
      ram_q <= '0;
    end else begin
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      if (bus.mem_re) ram_q <= ram[bus.mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  logic [7:0]        ref_mem [NBYTES];
  int                b_cnt;
  logic [MEM_AW-1:0] b_addr [2];
  logic [3:0]        b_be [2];
  logic [31:0]       b_wd [2];
  logic              b_we [2];
  logic              mutex_bad;
  logic [2:0]        ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          beats;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural reference: byte-addressed memory, size/offset from funct3.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat, output int beats);
    int sz, off, base;
    logic legal, mis;
    logic [31:0] v;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    off   = int'(addr % 4);
    base  = int'(addr % NBYTES);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (off % sz) != 0;
`endif
    rd = '0; err = 1'b0; lat = 2; beats = 0;
    if (!legal || mis) begin
      err = 1'b1;
      return;
    end
    beats = (off + sz > 4) ? 2 : 1;
    lat   = beats + 2;
    if (wr) begin
      for (int i = 0; i < sz; i++) ref_mem[(base + i) % NBYTES] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(base + i) % NBYTES];
      case (f3)
        3'd0:    rd = {{24{v[7]}}, v[7:0]};
        3'd1:    rd = {{16{v[15]}}, v[15:0]};
        3'd4:    rd = {24'h0, v[7:0]};
        3'd5:    rd = {16'h0, v[15:0]};
        default: rd = v;
      endcase
    end
  endtask

  // Issue one request at the current negedge and wait (bounded) for its response.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat);
    logic got;
    chk($sformatf("req_ready@%08h", addr), 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    lat = 0; b_cnt = 0; mutex_bad = 1'b0; got = 1'b0;
    rd = '0; err = 1'b0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_write  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
      end
      if (bus.mem_re && bus.mem_we) mutex_bad = 1'b1;
      if (bus.mem_re || bus.mem_we) begin
        if (b_cnt < 2) begin
          b_addr[b_cnt] = bus.mem_addr;
          b_be[b_cnt]   = bus.mem_be;
          b_wd[b_cnt]   = bus.mem_wdata;
          b_we[b_cnt]   = bus.mem_we;
        end
        b_cnt++;
      end
      if (bus.rsp_valid) begin
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("rsp_seen@%08h", addr), 32'(got), 32'd1);
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    logic [31:0] erd, rd;
    logic eerr, err;
    int elat, ebeats, lat;
    model(wr, f3, addr, wd, erd, eerr, elat, ebeats);
    do_req(wr, f3, addr, wd, rd, err, lat);
    chk($sformatf("rdata wr=%0d f3=%0d @%08h", wr, f3, addr), rd, erd);
    chk($sformatf("err wr=%0d f3=%0d @%08h", wr, f3, addr), 32'(err), 32'(eerr));
    chk($sformatf("latency @%08h", addr), 32'(lat), 32'(elat));
    chk($sformatf("beats @%08h", addr), 32'(b_cnt), 32'(ebeats));
    chk($sformatf("re_we_excl @%08h", addr), 32'(mutex_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, xrd;
    logic err, xerr;
    int lat, xlat, xbeats;
    logic wr;
    logic [2:0] f3;
    logic [31:0] addr;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_ctrl", {26'd0, bus.mem_re, bus.mem_we, bus.mem_be}, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b1;
    clr   = 1'b0;
    @(negedge clk); @(negedge clk);

    // Directed table: aligned and illegal accesses.
    vecs.push_back('{1'b1, F3_W,  32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 3, 1});
    vecs.push_back('{1'b0, F3_W,  32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1});
    vecs.push_back('{1'b1, F3_W,  32'h00, 32'h80FF7F01, 32'h0,        1'b0, 3, 1});
    vecs.push_back('{1'b0, F3_B,  32'h02, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 1});
    vecs.push_back('{1'b0, F3_BU, 32'h02, 32'h0,        32'h000000FF, 1'b0, 3, 1});
    vecs.push_back('{1'b0, F3_H,  32'h02, 32'h0,        32'hFFFF80FF, 1'b0, 3, 1});
    vecs.push_back('{1'b0, F3_HU, 32'h02, 32'h0,        32'h000080FF, 1'b0, 3, 1});
    vecs.push_back('{1'b0, 3'b011, 32'h00, 32'h0,       32'h0,        1'b1, 2, 0});
    vecs.push_back('{1'b0, 3'b110, 32'h04, 32'h0,       32'h0,        1'b1, 2, 0});
    vecs.push_back('{1'b1, 3'b100, 32'h00, 32'h55555555, 32'h0,       1'b1, 2, 0});
    vecs.push_back('{1'b0, F3_W,  32'h00, 32'h0,        32'h80FF7F01, 1'b0, 3, 1});
    vecs.push_back('{1'b1, F3_B,  32'h09, 32'h777777AA, 32'h0,        1'b0, 3, 1});
    vecs.push_back('{1'b1, F3_H,  32'h0A, 32'h99991234, 32'h0,        1'b0, 3, 1});
    vecs.push_back('{1'b0, F3_W,  32'h08, 32'h0,        32'h1234AAEF, 1'b0, 3, 1});
    vecs.push_back('{1'b0, F3_W,  32'h12340008, 32'h0,  32'h1234AAEF, 1'b0, 3, 1});
    foreach (vecs[i]) begin
      model(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, xrd, xerr, xlat, xbeats);
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_beats", i), 32'(b_cnt), 32'(vecs[i].beats));
    end

    // Split word store across words 3/4, then read it back.
    model(1'b1, F3_W, 32'h0F, 32'h11223344, xrd, xerr, xlat, xbeats);
    do_req(1'b1, F3_W, 32'h0F, 32'h11223344, rd, err, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("split_st_err", 32'(err), 32'd1);
    chk("split_st_beats", 32'(b_cnt), 32'd0);
    chk("split_st_lat", 32'(lat), 32'd2);
`else
    chk("split_st_beats", 32'(b_cnt), 32'd2);
    chk("split_st_b0", {b_we[0], 3'd0, b_be[0], 14'd0, 10'(b_addr[0])}, {1'b1, 3'd0, 4'h8, 14'd0, 10'd3});
    chk("split_st_b0_wd", b_wd[0], 32'h44000000);
    chk("split_st_b1", {b_we[1], 3'd0, b_be[1], 14'd0, 10'(b_addr[1])}, {1'b1, 3'd0, 4'h7, 14'd0, 10'd4});
    chk("split_st_b1_wd", b_wd[1], 32'h00112233);
    model(1'b0, F3_W, 32'h0F, 32'h0, xrd, xerr, xlat, xbeats);
    do_req(1'b0, F3_W, 32'h0F, 32'h0, rd, err, lat);
    chk("split_ld_rdata", rd, 32'h11223344);
    chk("split_ld_lat", 32'(lat), 32'd4);
`endif

    // Half store on the last byte of RAM wraps its second beat to word 0.
    model(1'b1, F3_H, 32'(NBYTES - 1), 32'h0000ABCD, xrd, xerr, xlat, xbeats);
    do_req(1'b1, F3_H, 32'(NBYTES - 1), 32'h0000ABCD, rd, err, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("wrap_st_err", 32'(err), 32'd1);
    chk("wrap_st_beats", 32'(b_cnt), 32'd0);
`else
    chk("wrap_st_beats", 32'(b_cnt), 32'd2);
    chk("wrap_b0_addr", 32'(b_addr[0]), 32'(NWORDS - 1));
    chk("wrap_b0_be", 32'(b_be[0]), 32'h8);
    chk("wrap_b1_addr", 32'(b_addr[1]), 32'd0);
    chk("wrap_b1_be", 32'(b_be[1]), 32'h1);
    chk("wrap_b1_wd", b_wd[1], 32'h000000AB);
    model(1'b0, F3_H, 32'(NBYTES - 1), 32'h0, xrd, xerr, xlat, xbeats);
    do_req(1'b0, F3_H, 32'(NBYTES - 1), 32'h0, rd, err, lat);
    chk("wrap_ld_rdata", rd, 32'hFFFFABCD);
`endif
    run_req(1'b0, F3_W, 32'h02, 32'h0);

    // Reset during BEAT0 of a store must abandon the write.
    run_req(1'b1, F3_W, 32'h40, 32'hCAFEF00D);
    chk("rst_pre_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_beat0_we", 32'(bus.mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_we_drop", 32'(bus.mem_we), 32'd0);
    chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_post_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_post_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_ram_word10", ram[16], 32'hCAFEF00D);
    run_req(1'b0, F3_W, 32'h40, 32'h0);

    // Random traffic over a low region and the wrapping top of RAM.
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) addr = 32'($urandom_range(NBYTES - 8, NBYTES - 1));
      else addr = 32'($urandom_range(0, 47));
      addr = addr | ({$urandom} << 12);
      run_req(wr, f3, addr, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
